// File: rtl/regfile_port_scheduler_if.sv
// Bundle between the write/read requesters, the scheduler and the mode-multiplexed
// 32x32 register file. The scheduler sits on the slave side.
interface regfile_port_scheduler_if #(
    parameter int NUM_WR = 4
);
    logic [NUM_WR-1:0]    wr_valid;
    logic [NUM_WR-1:0]    wr_ready;
    logic [NUM_WR*5-1:0]  wr_addr;
    logic [NUM_WR*32-1:0] wr_data;

    logic                 rd_valid;
    logic                 rd_ready;
    logic [4:0]           rd_addr1;
    logic [4:0]           rd_addr2;
    logic                 rd_resp_valid;
    logic [31:0]          rd_data1;
    logic [31:0]          rd_data2;

    logic                 rf_mode;
    logic [4:0]           rf_waddr;
    logic [31:0]          rf_wdata;
    logic [4:0]           rf_raddr1;
    logic [4:0]           rf_raddr2;
    logic [31:0]          rf_rdata1;
    logic [31:0]          rf_rdata2;

    logic                 busy;

    modport master (
        output wr_valid, wr_addr, wr_data,
        output rd_valid, rd_addr1, rd_addr2,
        output rf_rdata1, rf_rdata2,
        input  wr_ready, rd_ready, rd_resp_valid, rd_data1, rd_data2,
        input  rf_mode, rf_waddr, rf_wdata, rf_raddr1, rf_raddr2, busy
    );

    modport slave (
        input  wr_valid, wr_addr, wr_data,
        input  rd_valid, rd_addr1, rd_addr2,
        input  rf_rdata1, rf_rdata2,
        output wr_ready, rd_ready, rd_resp_valid, rd_data1, rd_data2,
        output rf_mode, rf_waddr, rf_wdata, rf_raddr1, rf_raddr2, busy
    );
endinterface

// File: rtl/regfile_port_scheduler.sv
// Schedules one transfer per cycle onto a register file that is either in read or write mode:
// round-robin write-back requesters against a dual-address reader, with RAW and starvation guards.
module regfile_port_scheduler #(
    parameter int NUM_WR       = 4,
    parameter int STARVE_LIMIT = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    regfile_port_scheduler_if.slave bus
);
    localparam int               PTR_W      = (NUM_WR > 1) ? $clog2(NUM_WR) : 1;
    localparam logic [3:0]       STARVE_MAX = 4'(STARVE_LIMIT);
    localparam logic [PTR_W-1:0] LAST_IDX   = PTR_W'(NUM_WR - 1);

    logic [4:0]        wr_addr_arr [NUM_WR];
    logic [31:0]       wr_data_arr [NUM_WR];
    logic [NUM_WR-1:0] addr_hit;

    logic [PTR_W-1:0]  rr_ptr_reg;
    logic [3:0]        starve_cnt_reg;
    logic              rf_mode_reg;
    logic [4:0]        rf_waddr_reg;
    logic [31:0]       rf_wdata_reg;
    logic [4:0]        rf_raddr1_reg;
    logic [4:0]        rf_raddr2_reg;
    logic              rd_pend_reg;
    logic              rd_resp_valid_reg;
    logic [31:0]       rd_data1_reg;
    logic [31:0]       rd_data2_reg;

    logic              any_wr;
    logic              hazard;
    logic              rd_grant;
    logic              wr_grant;
    logic [PTR_W-1:0]  wr_sel;
    logic [PTR_W-1:0]  rr_ptr_next;
    logic [PTR_W:0]    cand;

    generate
        for (genvar gi = 0; gi < NUM_WR; gi++) begin : g_req
            assign wr_addr_arr[gi] = bus.wr_addr[gi*5 +: 5];
            assign wr_data_arr[gi] = bus.wr_data[gi*32 +: 32];
            // A pending write to either read address must land before that read may go.
            assign addr_hit[gi]    = bus.wr_valid[gi] &&
                                     ((bus.wr_addr[gi*5 +: 5] == bus.rd_addr1) ||
                                      (bus.wr_addr[gi*5 +: 5] == bus.rd_addr2));
        end
    endgenerate

    assign any_wr = |bus.wr_valid;
    assign hazard = |addr_hit;

    // Scan from the farthest offset down so the nearest valid index after rr_ptr wins.
    always_comb begin
        wr_sel = '0;
        cand   = '0;
        for (int k = NUM_WR - 1; k >= 0; k--) begin
            cand = {1'b0, rr_ptr_reg} + (PTR_W+1)'(k);
            if (cand >= (PTR_W+1)'(NUM_WR)) begin
                cand = cand - (PTR_W+1)'(NUM_WR);
            end
            if (bus.wr_valid[cand[PTR_W-1:0]]) begin
                wr_sel = cand[PTR_W-1:0];
            end
        end
    end

    assign rr_ptr_next = (wr_sel == LAST_IDX) ? '0 : wr_sel + 1'b1;

    assign rd_grant = rst_n && bus.rd_valid && !hazard &&
                      (!any_wr || (starve_cnt_reg < STARVE_MAX));
    assign wr_grant = rst_n && any_wr && !rd_grant;

    assign bus.rd_ready = rd_grant;
    assign bus.wr_ready = wr_grant ? (NUM_WR'(1) << wr_sel) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_reg        <= '0;
            starve_cnt_reg    <= '0;
            rf_mode_reg       <= 1'b0;
            rf_waddr_reg      <= '0;
            rf_wdata_reg      <= '0;
            rf_raddr1_reg     <= '0;
            rf_raddr2_reg     <= '0;
            rd_pend_reg       <= 1'b0;
            rd_resp_valid_reg <= 1'b0;
            rd_data1_reg      <= '0;
            rd_data2_reg      <= '0;
        end else begin
            rf_mode_reg       <= wr_grant;
            rd_pend_reg       <= rd_grant;
            rd_resp_valid_reg <= rd_pend_reg;

            if (wr_grant) begin
                rf_waddr_reg   <= wr_addr_arr[wr_sel];
                rf_wdata_reg   <= wr_data_arr[wr_sel];
                rr_ptr_reg     <= rr_ptr_next;
                starve_cnt_reg <= '0;
            end else if (rd_grant) begin
                rf_raddr1_reg <= bus.rd_addr1;
                rf_raddr2_reg <= bus.rd_addr2;
                if (!any_wr) begin
                    starve_cnt_reg <= '0;
                end else if (starve_cnt_reg < STARVE_MAX) begin
                    starve_cnt_reg <= starve_cnt_reg + 4'd1;
                end
            end

            // Register file read data is valid during the issue cycle of the read.
            if (rd_pend_reg) begin
                rd_data1_reg <= bus.rf_rdata1;
                rd_data2_reg <= bus.rf_rdata2;
            end
        end
    end

    assign bus.rf_mode       = rf_mode_reg;
    assign bus.rf_waddr      = rf_waddr_reg;
    assign bus.rf_wdata      = rf_wdata_reg;
    assign bus.rf_raddr1     = rf_raddr1_reg;
    assign bus.rf_raddr2     = rf_raddr2_reg;
    assign bus.rd_resp_valid = rd_resp_valid_reg;
    assign bus.rd_data1      = rd_data1_reg;
    assign bus.rd_data2      = rd_data2_reg;
    assign bus.busy          = rf_mode_reg | rd_pend_reg;
endmodule

// File: tb/tb_regfile_port_scheduler.sv
// Randomized and directed bench for regfile_port_scheduler against a grant/memory reference model,
// with a behavioural register file attached to the rf_* side.
`timescale 1ns/1ps
module tb_regfile_port_scheduler;
    localparam int NW = 4;
    localparam int SL = 3;
    localparam int RD = 8;   // grant code used for a read grant

    logic clk      = 1'b0;
    logic rst_n    = 1'b0;
    logic env_init = 1'b1;
    always #5 clk = ~clk;

    regfile_port_scheduler_if #(.NUM_WR(NW)) bus();

    regfile_port_scheduler #(.NUM_WR(NW), .STARVE_LIMIT(SL)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    function automatic logic [31:0] seed_word(input int i);
        return (32'(i) * 32'h9E3779B9) ^ 32'h5A5A0000;
    endfunction

    // Behavioural register file: writes commit on the edge closing a rf_mode=1 cycle.
    logic [31:0] env_mem [32];
    always @(posedge clk) begin
        if (env_init) begin
            for (int i = 0; i < 32; i++) env_mem[i] <= seed_word(i);
        end else if (bus.rf_mode) begin
            env_mem[bus.rf_waddr] <= bus.rf_wdata;
        end
    end
    assign bus.rf_rdata1 = env_mem[bus.rf_raddr1];
    assign bus.rf_rdata2 = env_mem[bus.rf_raddr2];

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Stimulus held by the requesters
    logic [NW-1:0] s_wv;
    logic [4:0]    s_wa [NW];
    logic [31:0]   s_wd [NW];
    logic          s_rv;
    logic [4:0]    s_ra1, s_ra2;

    // Reference model
    typedef struct {
        int          due;
        logic [31:0] d1;
        logic [31:0] d2;
    } resp_t;

    logic [31:0] ref_mem [32];
    resp_t       rq[$];
    int          m_rr, m_starve, cyc, last_grant, n_resp;
    bit          pend_w;
    logic [4:0]  pend_a;
    logic [31:0] pend_d;
    logic [31:0] last_d1, last_d2;

    // One cycle: drive after a falling edge, check grants, predict, then check registered outputs.
    task automatic step();
        logic [NW-1:0] exp_wr_rdy;
        bit            any_w, haz, g_rd;
        int            sel;
        resp_t         r;
        for (int i = 0; i < NW; i++) begin
            bus.wr_addr[i*5 +: 5]   = s_wa[i];
            bus.wr_data[i*32 +: 32] = s_wd[i];
        end
        bus.wr_valid = s_wv;
        bus.rd_valid = s_rv;
        bus.rd_addr1 = s_ra1;
        bus.rd_addr2 = s_ra2;
        #1;
        any_w = (s_wv != '0);
        haz   = 1'b0;
        for (int i = 0; i < NW; i++)
            if (s_wv[i] && (s_wa[i] == s_ra1 || s_wa[i] == s_ra2)) haz = 1'b1;
        g_rd = s_rv && !haz && (!any_w || m_starve < SL);
        sel  = -1;
        if (!g_rd && any_w)
            for (int k = 0; k < NW && sel < 0; k++)
                if (s_wv[(m_rr + k) % NW]) sel = (m_rr + k) % NW;
        exp_wr_rdy = '0;
        if (sel >= 0) exp_wr_rdy[sel] = 1'b1;
        check("rd_ready", bus.rd_ready, g_rd);
        check("wr_ready", bus.wr_ready, exp_wr_rdy);
        last_grant = g_rd ? RD : sel;

        if (pend_w) ref_mem[pend_a] = pend_d;
        pend_w = (sel >= 0);
        if (sel >= 0) begin
            pend_a   = s_wa[sel];
            pend_d   = s_wd[sel];
            m_rr     = (sel + 1) % NW;
            m_starve = 0;
        end
        if (g_rd) begin
            r.due = cyc + 2;
            r.d1  = ref_mem[s_ra1];
            r.d2  = ref_mem[s_ra2];
            rq.push_back(r);
            m_starve = any_w ? ((m_starve < SL) ? m_starve + 1 : SL) : 0;
        end

        @(negedge clk);
        cyc++;
        check("rf_mode", bus.rf_mode, sel >= 0);
        if (sel >= 0) begin
            check("rf_waddr", bus.rf_waddr, pend_a);
            check("rf_wdata", bus.rf_wdata, pend_d);
        end
        if (g_rd) begin
            check("rf_raddr1", bus.rf_raddr1, s_ra1);
            check("rf_raddr2", bus.rf_raddr2, s_ra2);
        end
        check("busy", bus.busy, (sel >= 0) || g_rd);
        if (rq.size() > 0 && rq[0].due == cyc) begin
            r = rq.pop_front();
            check("rd_resp_valid", bus.rd_resp_valid, 1'b1);
            check("rd_data1", bus.rd_data1, r.d1);
            check("rd_data2", bus.rd_data2, r.d2);
            last_d1 = bus.rd_data1;
            last_d2 = bus.rd_data2;
            n_resp++;
        end else begin
            check("rd_resp_valid", bus.rd_resp_valid, 1'b0);
        end
    endtask

    initial begin
        int          exp_seq [8];
        int          n0;
        logic [31:0] hz_data;

        s_wv = '0; s_rv = 1'b0; s_ra1 = '0; s_ra2 = '0;
        for (int i = 0; i < NW; i++) begin s_wa[i] = '0; s_wd[i] = '0; end
        for (int i = 0; i < 32; i++) ref_mem[i] = seed_word(i);
        m_rr = 0; m_starve = 0; cyc = 0; last_grant = -1; n_resp = 0;
        pend_w = 1'b0; pend_a = '0; pend_d = '0; last_d1 = '0; last_d2 = '0;

        // Reset: requests present but nothing may be granted
        bus.wr_valid = '1; bus.wr_addr = '0; bus.wr_data = '0;
        bus.rd_valid = 1'b1; bus.rd_addr1 = 5'd1; bus.rd_addr2 = 5'd2;
        repeat (3) @(negedge clk);
        #1;
        check("rst_rd_ready", bus.rd_ready, 1'b0);
        check("rst_wr_ready", bus.wr_ready, 4'b0);
        check("rst_rf_mode", bus.rf_mode, 1'b0);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_resp_valid", bus.rd_resp_valid, 1'b0);
        check("rst_rf_waddr", bus.rf_waddr, 5'd0);
        check("rst_rf_wdata", bus.rf_wdata, 32'd0);
        check("rst_rf_raddr1", bus.rf_raddr1, 5'd0);
        check("rst_rd_data1", bus.rd_data1, 32'd0);
        bus.wr_valid = '0; bus.rd_valid = 1'b0;
        env_init = 1'b0;
        rst_n    = 1'b1;
        @(negedge clk);

        // Round-robin with all requesters busy
        s_wv = '1;
        for (int i = 0; i < NW; i++) begin s_wa[i] = 5'(16 + i); s_wd[i] = $urandom; end
        for (int k = 0; k < 8; k++) begin
            step();
            check("rr_order", last_grant, k % NW);
            if (last_grant >= 0 && last_grant < NW) s_wd[last_grant] = $urandom;
        end
        s_wv = '0;
        step();

        // Single write, idle, then read of the written address
        s_wv = 4'b0100; s_wa[2] = 5'd5; s_wd[2] = 32'hDEADBEEF;
        step();
        check("sw_grant", last_grant, 2);
        s_wv = '0;
        step();
        s_rv = 1'b1; s_ra1 = 5'd5; s_ra2 = 5'd0;
        step();
        check("sr_grant", last_grant, RD);
        s_rv = 1'b0;
        step();
        step();
        check("sr_rd_data1", last_d1, 32'hDEADBEEF);

        // Starvation limit with a continuously pending writer
        exp_seq = '{RD, RD, RD, 1, RD, RD, RD, 1};
        s_wv = 4'b0010; s_wa[1] = 5'd3; s_wd[1] = $urandom;
        s_rv = 1'b1; s_ra1 = 5'd20; s_ra2 = 5'd21;
        for (int k = 0; k < 8; k++) begin
            step();
            check("starve_order", last_grant, exp_seq[k]);
            if (last_grant == 1) s_wd[1] = $urandom;
        end
        s_wv = '0; s_rv = 1'b0;
        step(); step();

        // RAW hazard: write drains first, read returns the new value
        hz_data = $urandom;
        s_wv = 4'b0001; s_wa[0] = 5'd9; s_wd[0] = hz_data;
        s_rv = 1'b1; s_ra1 = 5'd1; s_ra2 = 5'd9;
        step();
        check("hz_first", last_grant, 0);
        s_wv = '0;
        step();
        check("hz_second", last_grant, RD);
        s_rv = 1'b0;
        step(); step();
        check("hz_rd_data2", last_d2, hz_data);

        // Back-to-back reads at full throughput
        n0 = n_resp;
        s_rv = 1'b1;
        for (int k = 0; k < 4; k++) begin
            s_ra1 = 5'(k * 3); s_ra2 = 5'(31 - k);
            step();
            check("b2b_grant", last_grant, RD);
        end
        s_rv = 1'b0;
        step(); step();
        check("b2b_resp_count", n_resp - n0, 4);

        // Reset while a write sits in the issue stage
        s_wv = 4'b1000; s_wa[3] = 5'd12; s_wd[3] = 32'h12345678;
        step();
        check("mid_grant", last_grant, 3);
        rst_n = 1'b0;
        #1;
        check("mid_rst_rf_mode", bus.rf_mode, 1'b0);
        check("mid_rst_wr_ready", bus.wr_ready, 4'b0);
        check("mid_rst_busy", bus.busy, 1'b0);
        pend_w = 1'b0; rq.delete(); m_rr = 0; m_starve = 0;
        repeat (2) @(negedge clk);
        cyc += 2;
        rst_n = 1'b1;
        check("mid_rst_no_write", env_mem[12], seed_word(12));
        s_wv = '1;
        for (int i = 0; i < NW; i++) begin s_wa[i] = 5'(24 + i); s_wd[i] = $urandom; end
        step();
        check("post_rst_first", last_grant, 0);
        s_wv = '0;
        step();

        // Randomized traffic over a small address range to provoke hazards
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < NW; i++) begin
                if (!s_wv[i] && $urandom_range(0, 3) == 0) begin
                    s_wv[i] = 1'b1;
                    s_wa[i] = 5'($urandom_range(0, 7));
                    s_wd[i] = $urandom;
                end
            end
            if (!s_rv && $urandom_range(0, 2) == 0) begin
                s_rv  = 1'b1;
                s_ra1 = 5'($urandom_range(0, 7));
                s_ra2 = 5'($urandom_range(0, 7));
            end
            step();
            if (last_grant == RD) s_rv = 1'b0;
            else if (last_grant >= 0) s_wv[last_grant] = 1'b0;
        end
        s_wv = '0; s_rv = 1'b0;
        repeat (3) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
